codec_op_sequencer: RTL



---
 rtl/codec_op_sequencer_if.sv | 38 +++
 rtl/codec_op_sequencer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/codec_op_sequencer_if.sv
// APB slave port plus codec core control/status, bundled for the op sequencer.
// The sequencer uses the slave view; the fabric and core side use the master view.
interface codec_op_sequencer_if #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 32,
  parameter int AMBA_WORD       = 32
);
  logic [AMBA_ADDR_WIDTH-1:0] PADDR;
  logic                       PSEL;
  logic                       PENABLE;
  logic                       PWRITE;
  logic [AMBA_WORD-1:0]       PWDATA;
  logic [AMBA_WORD-1:0]       PRDATA;
  logic                       PSLVERR;

  logic                       core_start;
  logic [1:0]                 core_ctrl;
  logic [DATA_WIDTH-1:0]      core_data_in;
  logic [1:0]                 core_width;
  logic [DATA_WIDTH-1:0]      core_noise;
  logic                       core_done;
  logic [DATA_WIDTH-1:0]      core_data_out;
  logic [1:0]                 core_num_err;

  modport slave (
    input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    output PRDATA, PSLVERR,
    output core_start, core_ctrl, core_data_in, core_width, core_noise,
    input  core_done, core_data_out, core_num_err
  );

  modport master (
    output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
    input  PRDATA, PSLVERR,
    input  core_start, core_ctrl, core_data_in, core_width, core_noise,
    output core_done, core_data_out, core_num_err
  );
endinterface

// File: rtl/codec_op_sequencer.sv
// APB-programmed launcher for one codec core operation: start pulse, wait with timeout,
// latch result. Zero-wait-state APB; writes while busy or CTRL=3 are refused with PSLVERR.
module codec_op_sequencer #(
  parameter int DATA_WIDTH      = 32,
  parameter int AMBA_ADDR_WIDTH = 32,
  parameter int AMBA_WORD       = 32,
  parameter int TIMEOUT_CYCLES  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  codec_op_sequencer_if.slave   bus,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [1:0]            num_of_errors,
  output logic                  operation_done,
  output logic                  busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

  state_t                state_q, state_d;
  logic [1:0]            ctrl_q, ctrl_d;
  logic [DATA_WIDTH-1:0] din_q, din_d;
  logic [1:0]            width_q, width_d;
  logic [DATA_WIDTH-1:0] noise_q, noise_d;
  logic [9:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic [1:0]            nerr_q, nerr_d;

  logic                  wr_en;
  logic                  wr_bad;
  logic                  wr_ok;
  logic                  launch;
  logic [1:0]            addr;
  logic [AMBA_WORD-1:0]  prdata;
  logic                  unused_bits;

  assign unused_bits = ^{bus.PADDR, bus.PWDATA};

  always_comb begin
    addr   = bus.PADDR[3:2];
    wr_en  = bus.PSEL & bus.PENABLE & bus.PWRITE;
    // Registers feed the core directly, so any write outside IDLE must be refused.
    wr_bad = wr_en & ((state_q != ST_IDLE) |
                      ((addr == 2'd0) & (bus.PWDATA[1:0] == 2'b11)));
    wr_ok  = wr_en & ~wr_bad;
    launch = wr_ok & (addr == 2'd0);

    prdata = '0;
    if (bus.PSEL && !bus.PWRITE) begin
      case (addr)
        2'd0:    prdata = AMBA_WORD'(ctrl_q);
        2'd1:    prdata = AMBA_WORD'(din_q);
        2'd2:    prdata = AMBA_WORD'(width_q);
        default: prdata = AMBA_WORD'(noise_q);
      endcase
    end
  end

  always_comb begin
    ctrl_d  = ctrl_q;
    din_d   = din_q;
    width_d = width_q;
    noise_d = noise_q;
    if (wr_ok) begin
      case (addr)
        2'd0:    ctrl_d  = bus.PWDATA[1:0];
        2'd1:    din_d   = bus.PWDATA[DATA_WIDTH-1:0];
        2'd2:    width_d = bus.PWDATA[1:0];
        default: noise_d = bus.PWDATA[DATA_WIDTH-1:0];
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    nerr_d  = nerr_q;
    case (state_q)
      ST_IDLE: begin
        if (launch) state_d = ST_START;
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.core_done) begin
          state_d = ST_DONE;
          dout_d  = bus.core_data_out;
          // Encode has no error count; the core's value is meaningless there.
          nerr_d  = (ctrl_q == 2'd0) ? 2'b00 : bus.core_num_err;
        end else if (cnt_q == TO_LAST) begin
          state_d = ST_DONE;
          dout_d  = '0;
          nerr_d  = 2'b11;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
      din_q   <= '0;
      width_q <= '0;
      noise_q <= '0;
      cnt_q   <= '0;
      dout_q  <= '0;
      nerr_q  <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      din_q   <= din_d;
      width_q <= width_d;
      noise_q <= noise_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      nerr_q  <= nerr_d;
    end
  end

  assign bus.PRDATA       = prdata;
  assign bus.PSLVERR      = wr_bad;
  assign bus.core_start   = (state_q == ST_START);
  assign bus.core_ctrl    = ctrl_q;
  assign bus.core_data_in = din_q;
  assign bus.core_width   = width_q;
  assign bus.core_noise   = noise_q;

  assign data_out       = dout_q;
  assign num_of_errors  = nerr_q;
  assign operation_done = (state_q == ST_DONE);
  assign busy           = (state_q != ST_IDLE);

endmodule
